// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges NUM_REQ byte streams into one UART input
// pipeline with atomic messages. Optional stall watchdog: UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk_48mhz,
    input  logic                 reset_n,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_in_data,
    output logic                 uart_in_valid,
    input  logic                 uart_in_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout
);

    localparam int                 IDX_W     = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_owner_q, last_owner_d;
    logic                 out_valid_q, out_valid_d;
    logic [7:0]           out_data_q, out_data_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;

    logic [IDX_W:0]       pick_s;
    logic [7:0]           gnt_data_s;
    logic                 gnt_valid_s;
    logic                 gnt_last_s;
    logic                 xfer_open_s;
    logic                 accept_s;

    // Returns {found, index} of the first valid requester after 'last', wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   last);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!found && valid[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Steer the granted requester's byte, valid and last flags.
    always_comb begin
        gnt_data_s = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt_data_s = gnt_data_s | (req_data[8*k +: 8] & {8{grant_q[k]}});
        end
        gnt_valid_s = |(req_valid & grant_q);
        gnt_last_s  = |(req_last & grant_q);
    end

    // A byte may enter only when the output register is empty or draining now.
    assign xfer_open_s = (state_q == ST_XFER) && (!out_valid_q || uart_in_ready);
    assign accept_s    = xfer_open_s && gnt_valid_s;
    assign req_ready   = grant_q & {NUM_REQ{xfer_open_s}};
    assign pick_s      = rr_pick(req_valid, last_owner_q);

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_hit_s;

    // Count consecutive granted cycles with the owner's valid low.
    always_comb begin
        stall_hit_s = 1'b0;
        stall_cnt_d = 16'h0000;
        if (state_q == ST_XFER && !gnt_valid_s) begin
            if (stall_cnt_q == STALL_LIMIT) begin
                stall_hit_s = 1'b1;
                stall_cnt_d = 16'h0000;
            end else begin
                stall_cnt_d = stall_cnt_q + 16'h0001;
            end
        end else begin
            stall_cnt_d = 16'h0000;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

    // Arbitration FSM and output register next-state.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        timeout_d    = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;

        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data_s;
        end else if (uart_in_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_s[IDX_W]) begin
                    state_d = ST_XFER;
                    owner_d = pick_s[IDX_W-1:0];
                    grant_d = GRANT_ONE << pick_s[IDX_W-1:0];
                end else begin
                    grant_d = '0;
                end
            end
            ST_XFER: begin
                if (accept_s && gnt_last_s) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    last_owner_d = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (stall_hit_s) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    last_owner_d = owner_q;
                    timeout_d    = 1'b1;
`endif
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d == ST_XFER) || out_valid_d;
    end

    // State and output registers; reset discards any partial message.
    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign grant         = grant_q;
    assign uart_in_valid = out_valid_q;
    assign uart_in_data  = out_data_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, idle-stall limit while granted (used only with UART_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk_48mhz  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_data  input  8*NUM_REQ  byte from requester i at bits [8i+7:8i].
REQ-006 SHALL have port req_valid  input  NUM_REQ  byte valid per requester.
REQ-007 SHALL have port req_last  input  NUM_REQ  marks final byte of a message per requester.
REQ-008 SHALL have port req_ready  output  NUM_REQ  byte accepted from requester i when req_valid[i] && req_ready[i].
REQ-009 SHALL have port uart_in_data  output  8  byte to the USB serial input pipeline.
REQ-010 SHALL have port uart_in_valid  output  1  uart_in_data is valid.
REQ-011 SHALL have port uart_in_ready  input  1  pipeline accepted byte when uart_in_valid && uart_in_ready.
REQ-012 SHALL have port grant  output  NUM_REQ  one-hot owner of the pipeline, 0 when idle.
REQ-013 SHALL have port busy  output  1  high while a message is granted or the output register is full.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-015 SHALL implement states IDLE and XFER.
REQ-016 In IDLE with any req_valid set, SHALL select the first requester with req_valid set, searching round-robin from (last owner + 1) mod NUM_REQ, load grant, and enter XFER next cycle; no bytes are accepted in the selection cycle.
REQ-017 In XFER SHALL assert req_ready only for the granted requester, and only when the output register is empty or being drained this cycle (!uart_in_valid || uart_in_ready).
REQ-018 An accepted byte SHALL appear on uart_in_data with uart_in_valid high on the next cycle (one-cycle latency); back-to-back acceptance SHALL sustain one byte per cycle while uart_in_ready stays high.
REQ-019 uart_in_valid SHALL NOT depend combinationally on uart_in_ready; once high, uart_in_valid and uart_in_data SHALL hold until the transfer completes (the pipeline does not raise ready before valid).
REQ-020 A message SHALL be atomic: grant SHALL NOT change until the byte carrying req_last is accepted.
REQ-021 On acceptance of a last byte SHALL return to IDLE, record owner as last owner, clear grant; the output register drains independently.
REQ-022 Non-granted requesters' req_valid SHALL be ignored and their bytes held by them, never dropped.
REQ-023 Single-byte message (req_valid and req_last together on first byte) SHALL be handled as a complete message.
REQ-024 Requester deasserting req_valid mid-message SHALL keep the grant (stall), subject to REQ-031.
REQ-025 Last-owner pointer SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-026 While reset_n is low at a clock edge, SHALL force state IDLE, grant=0, req_ready=0, uart_in_valid=0, uart_in_data=8'h00, busy=0, timeout=0, last owner=NUM_REQ-1 (so requester 0 wins first).
REQ-027 Reset mid-message SHALL discard the output register and any partial message without emitting further bytes.
REQ-028 First grant SHALL be possible in the first cycle after reset_n is sampled high.

Configuration
REQ-029 Macro UART_ARB_TIMEOUT_EN SHALL compile in a stall watchdog.
REQ-030 Without UART_ARB_TIMEOUT_EN, timeout SHALL be tied 0 and a stalled grant SHALL be held indefinitely.
REQ-031 With UART_ARB_TIMEOUT_EN, a 16-bit counter SHALL count consecutive XFER cycles with granted req_valid low, clear on any accepted byte, and at TIMEOUT_CYCLES SHALL return to IDLE, clear grant, advance last owner, and pulse timeout for one cycle.

Verification
REQ-032 Single requester 0 sends "Hi\r\n" with uart_in_ready=1 -> bytes 48 69 0D 0A on consecutive cycles, grant=0001 throughout, IDLE after 0A.
REQ-033 Requesters 0 and 1 both send 3-byte messages simultaneously after reset -> all of requester 0's bytes, then all of requester 1's, no interleave.
REQ-034 All four requesters continuously valid with 1-byte messages -> grant order 0,1,2,3,0.
REQ-035 uart_in_ready low for 5 cycles with uart_in_valid=1 data 0x41 -> data holds 0x41, req_ready low, no byte lost; resumes on ready.
REQ-036 Reset_n low for one cycle during byte 2 of a 4-byte message -> uart_in_valid=0 and grant=0 next cycle, requester 0 granted afresh afterwards.
REQ-037 With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, requester 2 stalls after first byte while requester 3 is valid -> timeout pulses once, requester 3 granted.
